// File: rtl/can_pkg.sv
// can_pkg: shared CAN bit-timing widths and bit-phase state type.
package can_pkg;
  localparam int BRP_W   = 6;
  localparam int TSEG1_W = 4;
  localparam int TSEG2_W = 3;
  localparam int SJW_W   = 2;
  // Wide enough for tseg1+1 plus the largest extension sjw+1.
  localparam int SEG_W   = TSEG1_W + 2;
  typedef enum logic [1:0] {SYNC, SEG1, SEG2} btl_state_t;
endpackage

// File: rtl/can_tq_prescaler.sv
// can_tq_prescaler: divides clk by brp+1 into time-quantum ticks.
module can_tq_prescaler
  import can_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [BRP_W-1:0] brp,
  input  logic             sync_clr,
  output logic             tq_tick
);
  logic [BRP_W-1:0] tq_cnt_q, tq_cnt_d;
  assign tq_tick  = enable && tq_cnt_q == brp;
  assign tq_cnt_d = (!enable || sync_clr || tq_tick) ? '0 : tq_cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tq_cnt_q <= '0;
    else tq_cnt_q <= tq_cnt_d;
endmodule

// File: rtl/can_btl.sv
// can_btl: CAN bit timing - SYNC/SEG1/SEG2 sequencing, hard sync and resync.
module can_btl
  import can_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [BRP_W-1:0]   brp,
  input  logic [TSEG1_W-1:0] tseg1,
  input  logic [TSEG2_W-1:0] tseg2,
  input  logic [SJW_W-1:0]   sjw,
  input  logic               hard_sync_en,
  input  logic               rx_in,
  output logic               sample_point,
  output logic               tx_point,
  output logic               rx_sampled
);
  btl_state_t       state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d, ext_q, ext_d, shr_q, shr_d, sjw1, r;
  logic lock_q, lock_d, first_q, first_d, rx_prev_q, tx_q, tx_d, sp_q, sp_d, rxs_q, rxs_d;
  logic tq_tick, edge_det, hard, late, early, seg1_end, seg2_end;

  can_tq_prescaler u_pre (
    .clk(clk), .rst_n(rst_n), .enable(enable), .brp(brp), .sync_clr(hard), .tq_tick(tq_tick)
  );

  assign sjw1     = SEG_W'(sjw) + 1'b1;
  assign r        = SEG_W'(tseg2) + 1'b1 - seg_q;
  assign edge_det = enable && rx_prev_q && !rx_in && rxs_q && !lock_q;
  // An early edge close enough to the bit end restarts the bit like a hard sync.
  assign hard     = edge_det && (hard_sync_en || (state_q == SEG2 && r <= sjw1));
  assign late     = edge_det && !hard_sync_en && state_q == SEG1;
  assign early    = edge_det && !hard_sync_en && state_q == SEG2 && r > sjw1;
  assign seg1_end = seg_q == SEG_W'(tseg1) + ext_q;
  assign seg2_end = seg_q + shr_q >= SEG_W'(tseg2);

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    ext_d   = ext_q;
    shr_d   = shr_q;
    lock_d  = lock_q;
    first_d = first_q;
    tx_d    = 1'b0;
    sp_d    = 1'b0;
    rxs_d   = rxs_q;
    if (!enable) begin
      state_d = SYNC;
      seg_d   = '0;
      ext_d   = '0;
      shr_d   = '0;
      lock_d  = 1'b0;
      first_d = 1'b1;
      rxs_d   = 1'b1;
    end else if (hard) begin
      state_d = SEG1;
      seg_d   = '0;
      ext_d   = '0;
      shr_d   = '0;
      lock_d  = 1'b1;
      first_d = 1'b0;
      tx_d    = 1'b1;
    end else if (late) begin
      ext_d  = (seg_q + 1'b1 < sjw1) ? seg_q + 1'b1 : sjw1;
      lock_d = 1'b1;
    end else if (early) begin
      shr_d  = sjw1;
      lock_d = 1'b1;
    end else if (tq_tick) begin
      case (state_q)
        SYNC: begin
          state_d = SEG1;
          seg_d   = '0;
          tx_d    = first_q;
          first_d = 1'b0;
        end
        SEG1: begin
          state_d = seg1_end ? SEG2 : SEG1;
          seg_d   = seg1_end ? '0 : seg_q + 1'b1;
          sp_d    = seg1_end;
          rxs_d   = seg1_end ? rx_in : rxs_q;
          lock_d  = seg1_end ? 1'b0 : lock_q;
        end
        SEG2: begin
          state_d = seg2_end ? SYNC : SEG2;
          seg_d   = seg2_end ? '0 : seg_q + 1'b1;
          ext_d   = seg2_end ? '0 : ext_q;
          shr_d   = seg2_end ? '0 : shr_q;
          tx_d    = seg2_end;
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= SYNC;
      seg_q     <= '0;
      ext_q     <= '0;
      shr_q     <= '0;
      lock_q    <= 1'b0;
      first_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      tx_q      <= 1'b0;
      sp_q      <= 1'b0;
      rxs_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      ext_q     <= ext_d;
      shr_q     <= shr_d;
      lock_q    <= lock_d;
      first_q   <= first_d;
      rx_prev_q <= rx_in;
      tx_q      <= tx_d;
      sp_q      <= sp_d;
      rxs_q     <= rxs_d;
    end

  assign tx_point     = tx_q;
  assign sample_point = sp_q;
  assign rx_sampled   = rxs_q;
endmodule
